// File: rtl/serial_alu_seq_if.sv
// Request/response bundle of the bit-serial ALU sequencer.
// The master issues operations and the slave (the sequencer) reports status and results.
interface serial_alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;

    modport master (
        output start, op, a, b, cin,
        input  busy, done, result, carry
    );

    modport slave (
        input  start, op, a, b, cin,
        output busy, done, result, carry
    );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer that drives an external 1-bit ALU slice, LSB first,
// chaining the carry itself so that the slice behaves as a WIDTH-bit ALU.
module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_alu_seq_if.slave  bus,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic [2:0]       alu_op,
    input  logic             alu_result,
    input  logic             alu_cout
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [2:0]       op_q;
    logic             cin_q;
    logic             c_q;
    logic             carry_q;
    logic [IW-1:0]    idx;

    logic accept;
    logic is_add;
    logic is_sub;
    logic is_slt;
    logic is_last;
    logic slt_bit;

    assign accept  = bus.start && (state != RUN);
    assign is_add  = (op_q == 3'b010);
    assign is_sub  = (op_q == 3'b110);
    assign is_slt  = (op_q == 3'b111);
    assign is_last = (idx == LAST);
    // Overflow-corrected sign: sum MSB xor (carry into MSB xor carry out of MSB).
    assign slt_bit = alu_result ^ c_q ^ alu_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (bus.start) next = RUN;
            RUN:     if (is_last)   next = DONE;
            DONE:    next = bus.start ? RUN : IDLE;
            default: next = IDLE;
        endcase
    end

    // The slice forces Cin=1 for ops 1xx, so SUB/SLT are run as ADD of ~b with a chained carry.
    always_comb begin
        alu_a   = 1'b0;
        alu_b   = 1'b0;
        alu_cin = 1'b0;
        alu_op  = 3'b000;
        if (state == RUN) begin
            alu_a = a_q[idx];
            if (is_add) begin
                alu_op  = 3'b010;
                alu_b   = b_q[idx];
                alu_cin = (idx == '0) ? cin_q : c_q;
            end else if (is_sub || is_slt) begin
                alu_op  = 3'b010;
                alu_b   = ~b_q[idx];
                alu_cin = (idx == '0) ? 1'b1 : c_q;
            end else begin
                alu_op  = op_q;
                alu_b   = b_q[idx];
                alu_cin = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'b000;
            cin_q   <= 1'b0;
            c_q     <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            cin_q   <= bus.cin;
            c_q     <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
        end else if (state == RUN) begin
            res_q[idx] <= alu_result;
            c_q        <= alu_cout;
            idx        <= idx + 1'b1;
            if (is_last) begin
                carry_q <= (is_add || is_sub) ? alu_cout : 1'b0;
                if (is_slt) begin
                    res_q <= {{(WIDTH-1){1'b0}}, slt_bit};
                end
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.result = res_q;
    assign bus.carry  = carry_q;
endmodule

// File: tb/tb_serial_alu_seq.sv
// Scoreboard bench for serial_alu_seq with a behavioural 1-bit ALU slice attached.
module tb_serial_alu_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_a;
    logic       alu_b;
    logic       alu_cin;
    logic [2:0] alu_op;
    logic       alu_result;
    logic       alu_cout;

    int checks = 0;
    int errors = 0;
    int tag_n  = 0;

    typedef struct {
        logic [7:0] res;
        logic       carry;
        int         tag;
    } exp_t;

    exp_t sbq[$];

    serial_alu_seq_if #(.WIDTH(8)) bus ();

    serial_alu_seq #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    always #5 clk = ~clk;

    // Stand-in for the team's 1-bit ALU slice; ops 1xx see a forced carry-in of 1.
    logic slice_cin;
    always_comb begin
        slice_cin  = alu_op[2] ? 1'b1 : alu_cin;
        alu_cout   = (alu_a & alu_b) | (alu_a & slice_cin) | (alu_b & slice_cin);
        alu_result = 1'b0;
        case (alu_op)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  alu_result = alu_a ^ alu_b ^ slice_cin;
            3'b011:  alu_result = alu_a ^ alu_b;
            3'b100:  alu_result = ~(alu_a & alu_b);
            3'b101:  alu_result = ~(alu_a | alu_b);
            default: alu_result = alu_a ^ ~alu_b ^ slice_cin;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no pending operation");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput($sformatf("result_%0d", e.tag), {24'd0, bus.result}, {24'd0, e.res});
                checkOutput($sformatf("carry_%0d", e.tag), {31'd0, bus.carry}, {31'd0, e.carry});
            end
        end
    end

    // Called just after a negedge; returns at the negedge where done is observed.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic [7:0] exp_res, input logic exp_carry,
                                 input int poke_bit);
        exp_t e;
        int   edges;
        int   bit_i;
        int   busy_cycles;
        logic sub;
        logic [2:0] exp_op;
        sub    = (op[2:1] == 2'b11);
        exp_op = (op == 3'b010 || sub) ? 3'b010 : op;
        e.res   = exp_res;
        e.carry = exp_carry;
        e.tag   = tag_n;
        tag_n++;
        sbq.push_back(e);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.start = 1'b1;
        @(posedge clk);
        edges       = 1;
        bit_i       = 0;
        busy_cycles = 0;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && edges < 20) begin
            bus.start = 1'b0;
            if (bus.busy === 1'b1) begin
                busy_cycles++;
                checkOutput($sformatf("alu_op_%0d_b%0d", e.tag, bit_i), {29'd0, alu_op}, {29'd0, exp_op});
                checkOutput($sformatf("alu_a_%0d_b%0d", e.tag, bit_i), {31'd0, alu_a}, {31'd0, a[bit_i]});
                checkOutput($sformatf("alu_b_%0d_b%0d", e.tag, bit_i), {31'd0, alu_b},
                            {31'd0, sub ? ~b[bit_i] : b[bit_i]});
                if (bit_i == 0) begin
                    checkOutput($sformatf("alu_cin0_%0d", e.tag), {31'd0, alu_cin},
                                {31'd0, (op == 3'b010) ? cin : sub});
                end
                if (bit_i == poke_bit) begin
                    bus.start = 1'b1;
                    bus.op    = 3'b001;
                    bus.a     = 8'hAA;
                    bus.b     = 8'h55;
                end
                bit_i++;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        checkOutput($sformatf("latency_%0d", e.tag), edges, 9);
        checkOutput($sformatf("busy_cycles_%0d", e.tag), busy_cycles, 8);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        bus.cin   = 1'b0;
        rst_n     = 1'b0;
        idleCycles(2);
        checkOutput("reset_busy", {31'd0, bus.busy}, 0);
        checkOutput("reset_done", {31'd0, bus.done}, 0);
        checkOutput("reset_result", {24'd0, bus.result}, 0);
        checkOutput("reset_carry", {31'd0, bus.carry}, 0);
        checkOutput("reset_alu", {26'd0, alu_a, alu_b, alu_cin, alu_op}, 0);
        rst_n = 1'b1;
        idleCycles(2);

        applyStimulus(3'b010, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, -1); idleCycles(2);
        applyStimulus(3'b010, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1); idleCycles(2);
        applyStimulus(3'b010, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, -1); idleCycles(2);
        applyStimulus(3'b110, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, -1); idleCycles(2);
        applyStimulus(3'b110, 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, -1); idleCycles(2);
        applyStimulus(3'b111, 8'h80, 8'h01, 1'b0, 8'h01, 1'b0, -1); idleCycles(2);
        applyStimulus(3'b111, 8'h7F, 8'h80, 1'b0, 8'h00, 1'b0, -1); idleCycles(2);
        applyStimulus(3'b111, 8'h05, 8'h05, 1'b0, 8'h00, 1'b0, -1); idleCycles(2);
        applyStimulus(3'b000, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, -1); idleCycles(2);
        applyStimulus(3'b001, 8'hF0, 8'h3C, 1'b0, 8'hFC, 1'b0, -1); idleCycles(2);
        applyStimulus(3'b011, 8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0, -1); idleCycles(2);
        applyStimulus(3'b100, 8'hF0, 8'h3C, 1'b1, 8'hCF, 1'b0, -1); idleCycles(2);
        applyStimulus(3'b101, 8'hF0, 8'h3C, 1'b0, 8'h03, 1'b0, -1); idleCycles(2);

        // start pulsed mid-operation must be ignored
        applyStimulus(3'b010, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 3); idleCycles(3);

        // back-to-back: second start issued during the DONE cycle
        applyStimulus(3'b010, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, -1);
        applyStimulus(3'b110, 8'h34, 8'h12, 1'b0, 8'h22, 1'b1, -1);
        idleCycles(2);

        // reset during RUN at bit 4 aborts with no done pulse
        bus.op    = 3'b010;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.cin   = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        idleCycles(4);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, bus.busy}, 0);
        checkOutput("abort_done", {31'd0, bus.done}, 0);
        checkOutput("abort_result", {24'd0, bus.result}, 0);
        checkOutput("abort_carry", {31'd0, bus.carry}, 0);
        checkOutput("abort_alu", {26'd0, alu_a, alu_b, alu_cin, alu_op}, 0);
        idleCycles(2);
        rst_n = 1'b1;
        idleCycles(15);
        checkOutput("abort_idle_busy", {31'd0, bus.busy}, 0);

        applyStimulus(3'b011, 8'hA5, 8'h0F, 1'b0, 8'hAA, 1'b0, -1);
        idleCycles(2);
        checkOutput("scoreboard_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
